// File: rtl/key_scan_encoder_pkg.sv
// Shared types and constants for the key scan encoder and its debounce cells.
package key_scan_encoder_pkg;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned DEB_W     = 4;
  localparam int unsigned DIV_W     = 16;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    EV_IDLE = 1'b0,
    EV_FULL = 1'b1
  } ev_state_e;

  typedef struct packed {
    logic  valid;
    code_t code;
  } key_event_t;

  // Encodes a vector with at most one bit set; OR-merging is exact for one-hot inputs.
  function automatic code_t onehot_to_code(input logic [NUM_LINES-1:0] vec);
    code_t code;
    code = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (vec[i]) code = code | CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// Debounce state for one key line; only updates on its own scan-slot sample.
module key_debounce_cell
  import key_scan_encoder_pkg::*;
#(
  parameter int unsigned DEB_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sample,
  output logic state_o,
  output logic rise_c
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // A disagreeing sample that completes the run flips the state and clears the count together.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_c  = 1'b0;
    if (en) begin
      if (sample == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ~state_q;
        rise_c  = ~state_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/key_scan_encoder.sv
// Scans 8 key lines through the external decoder, debounces each, and reports new presses.
module key_scan_encoder
  import key_scan_encoder_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [CODE_W-1:0]    scanCode,
  input  logic                 senseIn,
  output logic [CODE_W-1:0]    keyCode,
  output logic                 keyValid,
  input  logic                 keyReady,
  output logic [NUM_LINES-1:0] keyHeld,
  output logic                 keyLost
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]     div_q, div_d;
  code_t                scan_q, scan_d;
  logic [1:0]           sync_q, sync_d;
  logic                 sense_s;
  logic                 slot_end_c;
  logic [NUM_LINES-1:0] held_vec;
  logic [NUM_LINES-1:0] rise_vec;
  key_event_t           press_c;
  logic                 accept_c;

  ev_state_e            state_q, state_d;
  logic                 valid_q, valid_d;
  code_t                code_q, code_d;
  logic                 lost_q, lost_d;

  // Slot timing, scan counter and sense synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      scan_q <= '0;
      sync_q <= '0;
    end else begin
      div_q  <= div_d;
      scan_q <= scan_d;
      sync_q <= sync_d;
    end
  end

  always_comb begin
    slot_end_c = (div_q == DIV_LAST);
    div_d      = slot_end_c ? '0 : div_q + DIV_W'(1);
    scan_d     = slot_end_c ? scan_q + CODE_W'(1) : scan_q;
    sync_d     = {sync_q[0], senseIn};
    sense_s    = sync_q[1];
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_cell
    key_debounce_cell #(
      .DEB_CNT (DEB_CNT)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (slot_end_c && (scan_q == CODE_W'(i))),
      .sample  (sense_s),
      .state_o (held_vec[i]),
      .rise_c  (rise_vec[i])
    );
  end

  // At most one cell is enabled per edge, so rise_vec is one-hot or zero.
  always_comb begin
    press_c.valid = |rise_vec;
    press_c.code  = onehot_to_code(rise_vec);
    accept_c      = valid_q & keyReady;
  end

  // Event slot: state register plus registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EV_IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EV_IDLE: if (press_c.valid) state_d = EV_FULL;
      EV_FULL: if (accept_c && !press_c.valid) state_d = EV_IDLE;
      default: state_d = EV_IDLE;
    endcase
  end

  // A press into a full, un-drained slot is dropped and flagged instead of overwriting.
  always_comb begin
    code_d  = code_q;
    lost_d  = 1'b0;
    valid_d = (state_d == EV_FULL);
    case (state_q)
      EV_IDLE: if (press_c.valid) code_d = press_c.code;
      EV_FULL: begin
        if (press_c.valid) begin
          if (accept_c) code_d = press_c.code;
          else          lost_d = 1'b1;
        end
      end
      default: code_d = code_q;
    endcase
  end

  assign scanCode = scan_q;
  assign keyCode  = code_q;
  assign keyValid = valid_q;
  assign keyLost  = lost_q;
  assign keyHeld  = held_vec;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Randomised scoreboard bench for key_scan_encoder with a frame-level keyboard model.
module tb_key_scan_encoder;

  localparam int SD  = 4;
  localparam int DEB = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] scanCode;
  logic       sense_in;
  logic [2:0] keyCode;
  logic       keyValid;
  logic       keyReady;
  logic [7:0] keyHeld;
  logic       keyLost;
  logic [7:0] pressed;

  key_scan_encoder #(.SCAN_DIV(SD), .DEB_CNT(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scanCode (scanCode),
    .senseIn  (sense_in),
    .keyCode  (keyCode),
    .keyValid (keyValid),
    .keyReady (keyReady),
    .keyHeld  (keyHeld),
    .keyLost  (keyLost)
  );

  always #5 clk = ~clk;

  // The decoder returns the sense of whichever line is selected.
  always_comb sense_in = pressed[scanCode];

  // Reference model: per-line debounce and a one-deep event mailbox.
  logic [7:0] held_m;
  int         cnt_m [8];
  logic       mb_full;
  int         mb_code;
  logic       cur_valid;
  int         cur_code;
  int         exp_q [$];
  int         lost_q [$];
  int         cyc;
  bit         running;
  int         vectors;
  int         miscompares;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endfunction

  task automatic model_reset();
    held_m  = '0;
    mb_full = 1'b0;
    mb_code = 0;
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    exp_q.delete();
    lost_q.delete();
  endtask

  // Applies the edge that ends cycle c; cur_* capture what the DUT shows during cycle c.
  task automatic model_edge(input int c, input logic r);
    bit press;
    int pc;
    int line;
    bit hs;
    cur_valid = mb_full;
    cur_code  = mb_code;
    press     = 1'b0;
    pc        = 0;
    if (c % SD == SD - 1) begin
      line = (c / SD) % 8;
      if (pressed[line] == held_m[line]) begin
        cnt_m[line] = 0;
      end else begin
        cnt_m[line]++;
        if (cnt_m[line] == DEB) begin
          held_m[line] = ~held_m[line];
          cnt_m[line]  = 0;
          if (held_m[line]) begin
            press = 1'b1;
            pc    = line;
          end
        end
      end
    end
    hs = mb_full && r;
    if (press) begin
      if (!mb_full || hs) begin
        mb_full = 1'b1;
        mb_code = pc;
        exp_q.push_back(pc);
      end else begin
        lost_q.push_back(c + 1);
      end
    end else if (hs) begin
      mb_full = 1'b0;
    end
  endtask

  task automatic release_reset(input logic r);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    cyc      = 0;
    keyReady = r;
    model_edge(0, r);
    running  = 1'b1;
  endtask

  task automatic step(input logic r);
    @(posedge clk);
    #2;
    cyc++;
    keyReady = r;
    model_edge(cyc, r);
  endtask

  // Monitor: per-cycle output checks plus the handshake scoreboard.
  always @(negedge clk) begin
    if (running) begin
      bit exp_lost;
      chk("scanCode", int'(scanCode), (cyc / SD) % 8);
      chk("keyValid", int'(keyValid), int'(cur_valid));
      if (cur_valid) chk("keyCode", int'(keyCode), cur_code);
      if (cyc % SD == 0) chk("keyHeld", int'(keyHeld), int'(held_m));
      exp_lost = (lost_q.size() > 0) && (lost_q[0] == cyc);
      if (exp_lost) void'(lost_q.pop_front());
      chk("keyLost", int'(keyLost), int'(exp_lost));
      if (keyValid && keyReady) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL handshake_unexpected cyc=%0d actual=code %0d required=no event", cyc, keyCode);
        end else begin
          chk("handshake_code", int'(keyCode), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int stale;
    vectors     = 0;
    miscompares = 0;
    running     = 1'b0;
    cyc         = 0;
    rst_n       = 1'b0;
    keyReady    = 1'b0;
    pressed     = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_scanCode", int'(scanCode), 0);
    chk("reset_keyValid", int'(keyValid), 0);
    chk("reset_keyHeld",  int'(keyHeld),  0);
    chk("reset_keyLost",  int'(keyLost),  0);

    // Line 5 held, nobody draining; then line 2 (dropped) and line 6 (same-edge handoff).
    pressed = 8'h20;
    release_reset(1'b0);
    for (int k = 1; k < 200; k++) begin
      step(k == 187);
      if (k == 64)  pressed[2] = 1'b1;
      if (k == 128) pressed[6] = 1'b1;
    end

    // Asynchronous reset mid-slot with the line 6 event still pending.
    @(posedge clk);
    #3;
    running = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("async_scanCode", int'(scanCode), 0);
    chk("async_keyValid", int'(keyValid), 0);
    chk("async_keyCode",  int'(keyCode),  0);
    chk("async_keyHeld",  int'(keyHeld),  0);
    chk("async_keyLost",  int'(keyLost),  0);
    model_reset();
    @(posedge clk);
    release_reset(1'b0);
    for (int k = 1; k < 200; k++) step($urandom_range(99) < 30);

    // Random key activity, changed only at frame boundaries.
    for (int k = 0; k < 2800; k++) begin
      step($urandom_range(99) < 40);
      if (cyc % (8 * SD) == 0) begin
        for (int b = 0; b < 8; b++) begin
          if ($urandom_range(3) == 0) pressed[b] = ~pressed[b];
        end
      end
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    chk("pending_events", exp_q.size(), int'(mb_full));
    stale = 0;
    foreach (lost_q[i]) if (lost_q[i] <= cyc) stale++;
    chk("missed_lost_pulses", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
